bias_apply_seq: RTL and testbench
=================================

// Module: bias_apply_seq
// PURPOSE
//  Consumes the per-channel bias table (64 x 16-bit sign-magnitude words) and applies it
//  to the convolution accumulator stream of a fire expand layer.
//  Tracks the output channel of each accepted beat and adds the matching bias.
//  Saturates the sum to the data width and applies optional ReLU.
//  Sits between the MAC array output and the feature-map writer; 2-stage valid/ready pipeline.
// PARAMETERS
//  DATA_W   16  width of accumulator input and result, two's complement
//  BIAS_W   16  bias word width; bit BIAS_W-1 = sign, [BIAS_W-2:0] = magnitude
//  NUM_CH   64  channels per pixel; channel counter wraps at NUM_CH-1
//  RELU_EN  1   1: clamp negative results to 0; 0: pass signed result
// PORTS
//  clk        in   1                 clock, rising edge
//  rst_n      in   1                 asynchronous active-low reset
//  bias_mem   in   [NUM_CH][BIAS_W]  bias table, sign-magnitude, static during operation
//  ch_clr     in   1                 pulse: next accepted beat is channel 0 (new pixel/frame)
//  in_valid   in   1                 accumulator beat valid
//  in_ready   out  1                 block can accept a beat
//  in_data    in   DATA_W            accumulator value, signed
//  out_valid  out  1                 result beat valid
//  out_ready  in   1                 downstream accepts result
//  out_data   out  DATA_W            biased, saturated (and ReLU'd) result
//  out_ch     out  $clog2(NUM_CH)    channel index of out_data
//  out_last   out  1                 out_ch == NUM_CH-1 (last channel of pixel)
// BEHAVIOUR
//  Reset: ch_cnt=0, both stage valids=0, out_valid=0, out_data=0, out_ch=0, out_last=0.
//  Accept when in_valid && in_ready; output transfer when out_valid && out_ready.
//  in_ready = !v1 || (!v2 || out_ready); stage 1 advances into stage 2 when !v2 || out_ready.
//  Throughput 1 beat/cycle; latency 2 cycles from accept to out_valid with out_ready held high.
//  out_data/out_ch/out_last hold stable while out_valid && !out_ready; no beat lost or duplicated.
//  Stage 1 (on accept): capture in_data, ch = (ch_clr ? 0 : ch_cnt),
//   bias_tc = sign ? -{0,mag} : {0,mag}, sign-extended to DATA_W+2. 0x8000 (negative zero) -> 0.
//  Channel counter: on accept, ch_cnt <= ch+1, wrapping NUM_CH-1 -> 0.
//   ch_clr without accept: ch_cnt <= 0.
//   ch_clr with accept: beat uses channel 0; ch_cnt <= 1.
//  Stage 2: sum = sext(acc, DATA_W+2) + bias_tc.
//   Saturate: sum > 2^(DATA_W-1)-1 -> max; sum < -2^(DATA_W-1) -> min.
//   Then, if RELU_EN, negative results -> 0.
//  out_last = (out_ch == NUM_CH-1); registered with out_data.
//  Reset mid-stream: in-flight beats discarded, counter back to 0; no output after release
//   until a new accept.
//  Simultaneous push into stage 1 and pop from stage 2 in the same cycle is legal and
//   sustains full rate.
// STRUCTURE
//  Package fire_bias_pkg holds:
//   - DATA_W, BIAS_W, NUM_CH defaults;
//   - typedef bias_sm_t (packed struct {sign; mag});
//   - function sm_to_tc(); function sat_clip().
//  Sub-module bias_sm2tc: combinational sign-magnitude -> two's complement converter with
//   the table mux, reused by later fire layers.
//  Everything else (counter, 2-stage pipe, saturation, ReLU) is in this module.
// TESTING
//  1. Negative bias with ReLU off: bias[0]=0x80A1 (-161), in 1000 on ch 0 -> out_data 839,
//     out_ch 0, out_valid 2 cycles after accept.
//  2. ReLU clamp, RELU_EN=1: in 100 on ch 0 (bias -161) -> out_data 0;
//     in 100 on ch 3 (bias 0x0248 = 584) -> 684.
//  3. Saturation: ch 2 bias 0x0165 (357), in 32700 -> 32767;
//     RELU_EN=0, bias[5]=0x8041 (-65), in -32760 -> -32768.
//  4. Wrap/last: 128 back-to-back beats, out_ready=1 -> out_ch 0..63,0..63;
//     out_last high exactly on beats 63 and 127; 1 beat/cycle.
//  5. Backpressure: out_ready toggles randomly, in_valid held high for 64 beats
//     -> outputs in order, each exactly once, stable while stalled.
//  6. ch_clr + accept on beat 10 -> that beat reports ch 0, next ch 1.
//     rst_n low mid-stream -> out_valid=0 immediately; first post-reset beat is ch 0.

Source files
------------

// File: rtl/fire_bias_pkg.sv
// Shared types and arithmetic helpers for the fire-layer bias stages.
// Helpers take widths as arguments so one definition serves every layer width.
package fire_bias_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int BIAS_W_DEF = 16;
  localparam int NUM_CH_DEF = 64;

  typedef struct packed {
    logic                  sign;
    logic [BIAS_W_DEF-2:0] mag;
  } bias_sm_t;

  // Negative zero falls out naturally as 0 since -0 == 0.
  function automatic logic signed [31:0] sm_to_tc(input logic [31:0] sm,
                                                  input int unsigned bias_w);
    logic [31:0] mag;
    mag = sm & ((32'd1 << (bias_w - 1)) - 32'd1);
    return sm[5'(bias_w - 1)] ? -$signed(mag) : $signed(mag);
  endfunction

  function automatic logic signed [31:0] sat_clip(input logic signed [33:0] sum,
                                                  input int unsigned data_w);
    logic signed [33:0] max_v;
    logic signed [33:0] min_v;
    max_v = (34'sd1 <<< (data_w - 1)) - 34'sd1;
    min_v = -max_v - 34'sd1;
    if (sum > max_v) return $signed(max_v[31:0]);
    if (sum < min_v) return $signed(min_v[31:0]);
    return $signed(sum[31:0]);
  endfunction

endpackage

// File: rtl/bias_sm2tc.sv
// Bias table lookup plus sign-magnitude to two's complement conversion.
module bias_sm2tc
  import fire_bias_pkg::*;
#(
  parameter  int BIAS_W = BIAS_W_DEF,
  parameter  int NUM_CH = NUM_CH_DEF,
  parameter  int OUT_W  = DATA_W_DEF + 2,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0][BIAS_W-1:0] bias_mem,
  input  logic [CH_W-1:0]               sel,
  output logic signed [OUT_W-1:0]       bias_tc
);

  logic signed [31:0] tc_full;

  always_comb begin
    tc_full = sm_to_tc(32'(bias_mem[sel]), BIAS_W);
    bias_tc = tc_full[OUT_W-1:0];
  end

endmodule

// File: rtl/bias_apply_seq.sv
// Adds the per-channel bias to the accumulator stream, saturates and optionally
// applies ReLU, through a 2-stage valid/ready pipeline.
module bias_apply_seq
  import fire_bias_pkg::*;
#(
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int BIAS_W  = BIAS_W_DEF,
  parameter  int NUM_CH  = NUM_CH_DEF,
  parameter  bit RELU_EN = 1'b1,
  localparam int CH_W    = $clog2(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0][BIAS_W-1:0] bias_mem,
  input  logic                          ch_clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_W-1:0]      in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DATA_W-1:0]      out_data,
  output logic [CH_W-1:0]               out_ch,
  output logic                          out_last
);

  localparam int SUM_W = DATA_W + 2;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0]          ch_cnt_q, ch_cnt_d, ch_sel;
  logic                     vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic signed [DATA_W-1:0] acc_p1_q, acc_p1_d;
  logic signed [SUM_W-1:0]  bias_p1_q, bias_p1_d, bias_sel;
  logic [CH_W-1:0]          ch_p1_q, ch_p1_d;
  logic signed [DATA_W-1:0] data_p2_q, data_p2_d;
  logic [CH_W-1:0]          ch_p2_q, ch_p2_d;
  logic                     last_p2_q, last_p2_d;
  logic                     adv_p2, accept;
  logic signed [SUM_W-1:0]  sum_p2;
  logic signed [31:0]       sat_p2;

  assign adv_p2   = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || adv_p2;
  assign accept   = in_valid && in_ready;
  assign ch_sel   = ch_clr ? '0 : ch_cnt_q;

  bias_sm2tc #(
    .BIAS_W (BIAS_W),
    .NUM_CH (NUM_CH),
    .OUT_W  (SUM_W)
  ) u_sm2tc (
    .bias_mem (bias_mem),
    .sel      (ch_sel),
    .bias_tc  (bias_sel)
  );

  // Stage 1: capture accumulator, channel and converted bias
  always_comb begin
    ch_cnt_d  = ch_cnt_q;
    acc_p1_d  = acc_p1_q;
    bias_p1_d = bias_p1_q;
    ch_p1_d   = ch_p1_q;
    if (accept) begin
      ch_cnt_d  = (ch_sel == CH_LAST) ? '0 : ch_sel + 1'b1;
      acc_p1_d  = in_data;
      bias_p1_d = bias_sel;
      ch_p1_d   = ch_sel;
    end else if (ch_clr) begin
      ch_cnt_d = '0;
    end
    // in_ready implies stage 1 is vacated this cycle
    vld_p1_d = in_ready ? accept : vld_p1_q;
  end

  // Stage 2: add, saturate, ReLU
  always_comb begin
    vld_p2_d  = adv_p2 ? vld_p1_q : vld_p2_q;
    data_p2_d = data_p2_q;
    ch_p2_d   = ch_p2_q;
    last_p2_d = last_p2_q;
    sum_p2    = $signed({{2{acc_p1_q[DATA_W-1]}}, acc_p1_q}) + bias_p1_q;
    sat_p2    = sat_clip(34'(sum_p2), DATA_W);
    if (adv_p2 && vld_p1_q) begin
      data_p2_d = sat_p2[DATA_W-1:0];
      if (RELU_EN && data_p2_d[DATA_W-1]) data_p2_d = '0;
      ch_p2_d   = ch_p1_q;
      last_p2_d = (ch_p1_q == CH_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt_q  <= '0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      ch_p2_q   <= '0;
      last_p2_q <= 1'b0;
    end else begin
      ch_cnt_q  <= ch_cnt_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      ch_p2_q   <= ch_p2_d;
      last_p2_q <= last_p2_d;
    end
  end

  // Stage-1 payload is qualified by vld_p1_q, so it needs no reset
  always_ff @(posedge clk) begin
    acc_p1_q  <= acc_p1_d;
    bias_p1_q <= bias_p1_d;
    ch_p1_q   <= ch_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;
  assign out_ch    = ch_p2_q;
  assign out_last  = last_p2_q;

endmodule

// File: tb/tb_bias_apply_seq.sv
// Directed bench for bias_apply_seq: one ReLU and one linear instance share stimulus.
module tb_bias_apply_seq;
  import fire_bias_pkg::*;

  localparam int NCH = 64;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NCH-1:0][15:0]    bias_mem;
  logic                    ch_clr, in_valid, out_ready;
  logic signed [15:0]      in_data;
  logic                    in_ready_r, in_ready_l, out_valid_r, out_valid_l;
  logic                    out_last_r, out_last_l;
  logic signed [15:0]      out_data_r, out_data_l;
  logic [5:0]              out_ch_r, out_ch_l;

  always #5 clk = ~clk;

  bias_apply_seq #(.RELU_EN(1'b1)) dut_relu (
    .clk(clk), .rst_n(rst_n), .bias_mem(bias_mem), .ch_clr(ch_clr),
    .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
    .out_ch(out_ch_r), .out_last(out_last_r)
  );

  bias_apply_seq #(.RELU_EN(1'b0)) dut_lin (
    .clk(clk), .rst_n(rst_n), .bias_mem(bias_mem), .ch_clr(ch_clr),
    .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
    .out_ch(out_ch_l), .out_last(out_last_l)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  typedef struct {
    int     dr;
    int     dl;
    int     ch;
    int     last;
    longint cyc;
  } beat_t;

  beat_t  exp_q[$];
  beat_t  rx_q[$];
  int     tb_ch;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sm2int(input logic [15:0] b);
    return b[15] ? -int'(b[14:0]) : int'(b[14:0]);
  endfunction

  function automatic int model(input int acc, input int ch, input bit relu);
    int s;
    s = acc + sm2int(bias_mem[ch]);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  task automatic send(input int acc, input bit clr);
    int    n;
    int    ch;
    beat_t b;
    in_valid = 1'b1;
    in_data  = 16'(acc);
    ch_clr   = clr;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready_r) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    ch     = clr ? 0 : tb_ch;
    tb_ch  = (ch == NCH - 1) ? 0 : ch + 1;
    b.dr   = model(acc, ch, 1'b1);
    b.dl   = model(acc, ch, 1'b0);
    b.ch   = ch;
    b.last = (ch == NCH - 1) ? 1 : 0;
    b.cyc  = 0;
    exp_q.push_back(b);
    @(posedge clk);
    #1 in_valid = 1'b0;
    ch_clr = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic signed [15:0] held_d;
  logic [5:0]         held_ch;
  logic               held_last;
  bit                 held_v = 1'b0;

  always @(negedge clk) begin
    beat_t e;
    beat_t r;
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (out_valid_r != out_valid_l) chk("vld_pair", out_valid_l, out_valid_r);
      if (out_valid_r && out_ready) begin
        held_v = 1'b0;
        if (exp_q.size() == 0) begin
          chk("sb_extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data_relu", out_data_r, e.dr);
          chk("sb_data_lin", out_data_l, e.dl);
          chk("sb_ch", out_ch_r, e.ch);
          chk("sb_last", out_last_r, e.last);
        end
        r.dr = out_data_r; r.dl = out_data_l; r.ch = out_ch_r;
        r.last = out_last_r; r.cyc = cyc;
        rx_q.push_back(r);
      end else if (out_valid_r) begin
        if (held_v) begin
          chk("stall_data", out_data_r, held_d);
          chk("stall_ch", out_ch_r, held_ch);
          chk("stall_last", out_last_r, held_last);
        end
        held_v = 1'b1; held_d = out_data_r; held_ch = out_ch_r; held_last = out_last_r;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    bit done;
    bias_sm_t neg161;
    neg161 = '{sign: 1'b1, mag: 15'h00A1};
    for (int i = 0; i < NCH; i++) bias_mem[i] = 16'(i * 5);
    bias_mem[0] = neg161;
    bias_mem[1] = 16'h8000;
    bias_mem[2] = 16'h0165;
    bias_mem[3] = 16'h0248;
    bias_mem[5] = 16'h8041;
    rst_n = 1'b0; in_valid = 1'b0; ch_clr = 1'b0; in_data = '0; out_ready = 1'b1;
    tb_ch = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid_r, 0);
    chk("rst_out_data", out_data_l, 0);
    chk("rst_out_ch", out_ch_r, 0);
    chk("rst_out_last", out_last_r, 0);
    chk("rst_in_ready", in_ready_r, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // negative bias, linear, latency
    send(1000, 1'b0);
    chk("t1_lat_cyc1", out_valid_l, 0);
    @(posedge clk);
    #1;
    chk("t1_lat_cyc2", out_valid_l, 1);
    chk("t1_data", out_data_l, 839);
    chk("t1_ch", out_ch_l, 0);
    wait_drain();

    // ReLU clamp, negative zero, saturation both ways
    b = rx_q.size();
    send(100, 1'b1);
    send(7, 1'b0);
    send(32700, 1'b0);
    send(100, 1'b0);
    send(9, 1'b0);
    send(-32760, 1'b0);
    wait_drain();
    chk("t23_count", rx_q.size() - b, 6);
    if (rx_q.size() >= b + 6) begin
      chk("t2_relu_clamp", rx_q[b].dr, 0);
      chk("t2_lin_neg", rx_q[b].dl, -61);
      chk("t2_negzero", rx_q[b+1].dl, 7);
      chk("t3_sat_max", rx_q[b+2].dl, 32767);
      chk("t2_ch3", rx_q[b+3].dr, 684);
      chk("t3_sat_min", rx_q[b+5].dl, -32768);
      chk("t3_relu_min", rx_q[b+5].dr, 0);
    end

    // wrap and last over two pixels
    b = rx_q.size();
    for (int j = 0; j < 128; j++) send(j * 100 - 3000, j == 0);
    wait_drain();
    chk("t4_count", rx_q.size() - b, 128);
    if (rx_q.size() >= b + 128) begin
      for (int j = 0; j < 128; j++) begin
        chk("t4_ch", rx_q[b+j].ch, j % 64);
        chk("t4_last", rx_q[b+j].last, (j % 64 == 63) ? 1 : 0);
      end
      chk("t4_rate", rx_q[b+127].cyc - rx_q[b].cyc, 127);
    end

    // random backpressure
    b = rx_q.size();
    done = 1'b0;
    fork
      begin
        for (int j = 0; j < 64; j++) send(j * 900 - 28000, j == 0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    chk("t5_count", rx_q.size() - b, 64);

    // ch_clr mid-stream
    b = rx_q.size();
    for (int j = 0; j < 12; j++) send(j + 1, j == 10);
    wait_drain();
    chk("t6_count", rx_q.size() - b, 12);
    if (rx_q.size() >= b + 12) begin
      chk("t6_clr_ch", rx_q[b+10].ch, 0);
      chk("t6_clr_data", rx_q[b+10].dl, -150);
      chk("t6_next_ch", rx_q[b+11].ch, 1);
    end

    // reset with beats in flight
    out_ready = 1'b0;
    send(500, 1'b0);
    send(600, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_vld_relu", out_valid_r, 0);
    chk("t6_rst_vld_lin", out_valid_l, 0);
    exp_q.delete();
    tb_ch = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1 chk("t6_rst_quiet", out_valid_r, 0);
    end
    b = rx_q.size();
    send(50, 1'b0);
    wait_drain();
    chk("t6_post_count", rx_q.size() - b, 1);
    if (rx_q.size() >= b + 1) begin
      chk("t6_post_ch", rx_q[b].ch, 0);
      chk("t6_post_lin", rx_q[b].dl, -111);
      chk("t6_post_relu", rx_q[b].dr, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
